pwm_encoder: RTL and testbench

Frame-synchronous PWM generator: takes a duty word through a valid/ready handshake and drives a pulse of exactly that many clock ticks at the start of every fixed-length frame. It is the transmit counterpart of the sync-counter pulse-width decoder, which measures comparator high-time against a frame reset. With the default 10 kHz tick clock and 200-tick frame (50 Hz), its output feeds the decoder directly for loopback checks.

---
 rtl/pwm_encoder_pkg.sv | 20 ++
 rtl/pwm_encoder_frame_counter.sv | 29 ++
 rtl/pwm_encoder.sv | 148 ++++++++++++++
 tb/tb_pwm_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_encoder_pkg.sv
// Shared definitions for the frame-synchronous PWM encoder: FSM state
// encoding and the default frame geometry (10 kHz tick, 200-tick frame).
package pwm_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH     = 7;
  localparam int DEFAULT_PERIOD    = 200;
  localparam int DEFAULT_MAX_COUNT = 100;

  // Width of the frame index; a 1-bit counter is still needed for PERIOD=2.
  function automatic int count_width(input int period);
    return (period > 2) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/pwm_encoder_frame_counter.sv
// Mod-PERIOD frame index counter. Synchronous clear forces the index to 0;
// wrap flags the last cycle of a frame (index PERIOD-1).
module frame_counter #(
  parameter int PERIOD = 200,
  parameter int KW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic [KW-1:0] count,
  output logic          wrap
);

  localparam logic [KW-1:0] LAST = KW'(PERIOD - 1);

  assign wrap = (count == LAST);

  // Frame index: restart on clear or after the last cycle of the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || wrap) begin
      count <= '0;
    end else begin
      count <= count + KW'(1);
    end
  end

endmodule

// File: rtl/pwm_encoder.sv
// Frame-synchronous PWM encoder. A duty word arrives via valid/ready into a
// shadow register; at each frame boundary a pending shadow value becomes the
// active duty D, and pwm is high for the first D ticks of the frame.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | enable low; pwm low, frame index held at 0
//   HIGH    | frame running, index < D, pwm high
//   LOW     | frame running, index >= D, pwm low until frame wrap
module pwm_encoder
  import pwm_encoder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int PERIOD    = DEFAULT_PERIOD,
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_duty,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pwm,
  output logic             frame_start,
  output logic             busy
);

  localparam int KW = count_width(PERIOD);
  localparam int CW = ((KW > WIDTH) ? KW : WIDTH) + 1;
  localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MAX_COUNT);

  if (PERIOD < 2 || MAX_COUNT > PERIOD || MAX_COUNT >= (2 ** WIDTH)) begin : g_bad_params
    $error("pwm_encoder: need PERIOD >= 2, MAX_COUNT <= PERIOD, MAX_COUNT < 2**WIDTH");
  end

  state_t           state_q;
  state_t           state_nxt;
  logic [KW-1:0]    count;
  logic             wrap;
  logic             clear;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_nxt;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] duty_clamped;
  logic             pending_q;
  logic             pending_nxt;
  logic             accept;
  logic             boundary;
  logic             last_high;
  logic             frame_high;
  logic             pwm_nxt;
  logic             frame_start_nxt;
  logic             busy_nxt;
  logic             in_ready_nxt;

  // in_ready is a flop mirroring !pending, so accept uses only registered state
  // on the ready side.
  assign accept       = in_valid && in_ready;
  assign duty_clamped = (in_duty > MAX_D) ? MAX_D : in_duty;

  // The next cycle is index 0 of a frame: first enabled edge out of IDLE, or
  // the wrap of a running frame.
  assign boundary = enable && ((state_q == ST_IDLE) || wrap);
  assign clear    = !enable || (state_q == ST_IDLE);

  // A capture on a boundary edge cannot also load: accept needs pending low,
  // so the load sees the old shadow and the new word waits a full frame.
  assign duty_nxt    = (boundary && pending_q) ? shadow_q : duty_q;
  assign pending_nxt = accept ? 1'b1 : (boundary ? 1'b0 : pending_q);

  assign last_high  = ((CW'(count) + CW'(1)) == CW'(duty_q));
  assign frame_high = (duty_nxt != '0);

  frame_counter #(
    .PERIOD (PERIOD),
    .KW     (KW)
  ) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .count (count),
    .wrap  (wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; a boundary always restarts the frame from HIGH or LOW.
  always_comb begin
    state_nxt = state_q;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else if (boundary) begin
      state_nxt = frame_high ? ST_HIGH : ST_LOW;
    end else begin
      case (state_q)
        ST_HIGH: if (last_high) state_nxt = ST_LOW;
        ST_LOW:  state_nxt = ST_LOW;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state, so every output leaves a flop.
  always_comb begin
    pwm_nxt         = (state_nxt == ST_HIGH);
    busy_nxt        = (state_nxt != ST_IDLE);
    frame_start_nxt = boundary;
    in_ready_nxt    = !pending_nxt;
  end

  // Output registers; reset drops pwm asynchronously with no path back high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm         <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      pwm         <= pwm_nxt;
      busy        <= busy_nxt;
      frame_start <= frame_start_nxt;
      in_ready    <= in_ready_nxt;
    end
  end

  // Duty, shadow and pending flag; these survive enable drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      duty_q    <= duty_nxt;
      pending_q <= pending_nxt;
      if (accept) begin
        shadow_q <= duty_clamped;
      end
    end
  end

endmodule

// File: tb/tb_pwm_encoder.sv
// Directed bench for pwm_encoder with the default 200-tick frame.
module tb_pwm_encoder;

  localparam int WIDTH     = 7;
  localparam int PERIOD    = 200;
  localparam int MAX_COUNT = 100;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] in_duty;
  logic             in_valid;
  logic             in_ready;
  logic             pwm;
  logic             frame_start;
  logic             busy;

  int errors = 0;
  int checks = 0;

  pwm_encoder #(
    .WIDTH     (WIDTH),
    .PERIOD    (PERIOD),
    .MAX_COUNT (MAX_COUNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .in_duty     (in_duty),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pwm         (pwm),
    .frame_start (frame_start),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample n cycles starting with the current one; ends n edges later.
  task automatic measure(input int n, output int high, output bit shape_ok,
                         output int fs, output int rdy_low);
    bit seen_low;
    high = 0; shape_ok = 1'b1; fs = 0; rdy_low = 0; seen_low = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (pwm === 1'b1) begin
        high++;
        if (seen_low) shape_ok = 1'b0;
      end else begin
        seen_low = 1'b1;
      end
      if (frame_start === 1'b1) fs++;
      if (in_ready === 1'b0) rdy_low++;
      tick();
    end
  endtask

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD + 4; i++) begin
      tick();
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_duty = '0;
    tick(); tick();
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_idle_frames();
    int h, fs, rl;
    bit sh;
    enable = 1'b1;
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start: got %b expected 1", frame_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", busy); end
    for (int f = 0; f < 3; f++) begin
      measure(PERIOD, h, sh, fs, rl);
      checks++; if (h != 0) begin errors++; $display("FAIL zero_frame_high[%0d]: got %0d expected 0", f, h); end
      checks++; if (fs != 1) begin errors++; $display("FAIL zero_frame_starts[%0d]: got %0d expected 1", f, fs); end
      checks++; if (rl != 0) begin errors++; $display("FAIL zero_frame_ready_low[%0d]: got %0d expected 0", f, rl); end
    end
    enable = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disable_busy: got %b expected 0", busy); end
  endtask

  task automatic test_load_idle();
    int h, fs, rl;
    bit sh;
    in_duty = 7'd60; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_load_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_load_busy: got %b expected 0", busy); end
    enable = 1'b1;
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL load_frame_start: got %b expected 1", frame_start); end
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL load_first_pwm: got %b expected 1", pwm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready_back: got %b expected 1", in_ready); end
    for (int f = 0; f < 2; f++) begin
      measure(PERIOD, h, sh, fs, rl);
      checks++; if (h != 60) begin errors++; $display("FAIL duty60_high[%0d]: got %0d expected 60", f, h); end
      checks++; if (sh !== 1'b1) begin errors++; $display("FAIL duty60_shape[%0d]: got %b expected 1", f, sh); end
    end
  endtask

  task automatic test_clamp();
    int h, fs, rl;
    bit sh, ok;
    logic [WIDTH-1:0] req [5] = '{7'd127, 7'd0, 7'd100, 7'd101, 7'd1};
    int exp_high [5] = '{100, 0, 100, 100, 1};
    for (int i = 0; i < 5; i++) begin
      in_duty = req[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clamp_ready[%0d]: got %b expected 0", i, in_ready); end
      wait_frame_start(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clamp_frame_timeout[%0d]: got %b expected 1", i, ok); end
      measure(PERIOD, h, sh, fs, rl);
      checks++; if (h != exp_high[i]) begin errors++; $display("FAIL clamp_high[%0d]: got %0d expected %0d", i, h, exp_high[i]); end
      checks++; if (sh !== 1'b1) begin errors++; $display("FAIL clamp_shape[%0d]: got %b expected 1", i, sh); end
    end
  endtask

  task automatic test_boundary_capture();
    int h, fs, rl;
    bit sh, ok;
    in_duty = 7'd80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_frame_start(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bnd_frame_timeout: got %b expected 1", ok); end
    measure(PERIOD - 1, h, sh, fs, rl);
    checks++; if (h != 80) begin errors++; $display("FAIL bnd_pre_high: got %0d expected 80", h); end
    in_duty = 7'd30; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL bnd_frame_start: got %b expected 1", frame_start); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bnd_ready_low: got %b expected 0", in_ready); end
    measure(PERIOD, h, sh, fs, rl);
    checks++; if (h != 80) begin errors++; $display("FAIL bnd_same_frame_high: got %0d expected 80", h); end
    checks++; if (rl != PERIOD) begin errors++; $display("FAIL bnd_ready_low_span: got %0d expected %0d", rl, PERIOD); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready_rise: got %b expected 1", in_ready); end
    measure(PERIOD, h, sh, fs, rl);
    checks++; if (h != 30) begin errors++; $display("FAIL bnd_next_frame_high: got %0d expected 30", h); end
  endtask

  task automatic test_back_to_back();
    int h, fs, rl, stall;
    bit sh;
    logic p0;
    in_duty = 7'd10; in_valid = 1'b1;
    tick();
    in_duty = 7'd20;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b expected 0", in_ready); end
    stall = 0;
    while (in_ready === 1'b0 && stall < 2 * PERIOD) begin
      stall++;
      tick();
    end
    checks++; if (stall != PERIOD - 1) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected %0d", stall, PERIOD - 1); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL b2b_release_at_boundary: got %b expected 1", frame_start); end
    p0 = pwm;
    tick();
    in_valid = 1'b0;
    measure(PERIOD - 1, h, sh, fs, rl);
    h = h + int'(p0);
    checks++; if (h != 10) begin errors++; $display("FAIL b2b_first_high: got %0d expected 10", h); end
    measure(PERIOD, h, sh, fs, rl);
    checks++; if (h != 20) begin errors++; $display("FAIL b2b_second_high: got %0d expected 20", h); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end: got %b expected 1", in_ready); end
  endtask

  task automatic test_enable_drop();
    int h, fs, rl;
    bit sh, ok;
    in_duty = 7'd60; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_frame_start(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drop_frame_timeout: got %b expected 1", ok); end
    measure(35, h, sh, fs, rl);
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL drop_pwm_k35: got %b expected 1", pwm); end
    enable = 1'b0;
    tick();
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL drop_pwm_next: got %b expected 0", pwm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b expected 0", busy); end
    measure(3, h, sh, fs, rl);
    checks++; if (h != 0 || fs != 0) begin errors++; $display("FAIL drop_idle_quiet: got high=%0d starts=%0d expected 0 0", h, fs); end
    enable = 1'b1;
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reenable_start: got %b expected 1", frame_start); end
    measure(PERIOD, h, sh, fs, rl);
    checks++; if (h != 60) begin errors++; $display("FAIL reenable_high: got %0d expected 60", h); end
    checks++; if (fs != 1) begin errors++; $display("FAIL reenable_starts: got %0d expected 1", fs); end
  endtask

  task automatic test_reset_midframe();
    int h, fs, rl;
    bit sh;
    measure(35, h, sh, fs, rl);
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL rst_pwm_k35: got %b expected 1", pwm); end
    reset = 1'b0;
    #2;
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL rst_pwm_immediate: got %b expected 0", pwm); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_flags: got busy=%b ready=%b expected 0 1", busy, in_ready); end
    reset = 1'b1;
    tick();
    checks++; if (frame_start !== 1'b1 || pwm !== 1'b0) begin errors++; $display("FAIL rst_restart: got start=%b pwm=%b expected 1 0", frame_start, pwm); end
    measure(PERIOD, h, sh, fs, rl);
    checks++; if (h != 0) begin errors++; $display("FAIL rst_cleared_duty: got %0d expected 0", h); end
    enable = 1'b0;
    tick();
    in_duty = 7'd60; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    enable = 1'b1;
    tick();
    measure(PERIOD, h, sh, fs, rl);
    checks++; if (h != 60 || sh !== 1'b1) begin errors++; $display("FAIL rst_reload_high: got %0d shape=%b expected 60 1", h, sh); end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_load_idle();
    test_clamp();
    test_boundary_capture();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
